// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 scan-code decoder
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // Bytes the receiver emits when it saw a line error.
    function automatic logic is_err(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - synchronous FIFO holding decoded key events
// Ports: clk, rst_n (async active-low); push/push_data write side;
// pop/pop_data read side (pop_data shows the head, zero when empty);
// full/empty status flags.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a
    // push when it is being popped.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero when empty so idle outputs read as zero.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - turns PS/2 scan-code bytes into buffered key events
// Ports: clk, rst_n (async active-low); in_valid/in_byte from the serial
// receiver; out_valid/out_ready/out_code/out_ext/out_break event stream to
// the host; overflow pulses one cycle after an event is dropped on a full FIFO.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic       out_break,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          overflow_q, overflow_d;
    logic          push;
    ps2_evt_t      push_evt;
    ps2_evt_t      head_evt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    // State register and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            overflow_q <= overflow_d;
        end
    end

    // Next state. A byte arriving on the timeout cycle takes priority and is
    // decoded against the prefix still held.
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        if (in_valid) begin
            if (is_err(in_byte)) begin
                state_d = ST_IDLE;
            end else if (in_byte == PS2_EXT) begin
                // A fresh E0 always restarts an extended sequence; any
                // pending break is dropped.
                state_d = ST_EXT;
            end else if (in_byte == PS2_BRK) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_BRK;
                    ST_EXT:   state_d = ST_EXT_BRK;
                    default:  state_d = state_q;
                endcase
            end else begin
                state_d = ST_IDLE;
            end
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Event emission: any non-prefix, non-error byte completes an event whose
    // flags come straight from the prefix state it lands in.
    always_comb begin
        push     = 1'b0;
        push_evt = '0;
        if (in_valid && !is_err(in_byte) &&
            (in_byte != PS2_EXT) && (in_byte != PS2_BRK)) begin
            push          = 1'b1;
            push_evt.code = in_byte;
            push_evt.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
            push_evt.brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        end
    end

    assign pop        = out_valid && out_ready;
    assign overflow_d = push && fifo_full && !pop;

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_evt_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .pop_data  (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_code  = head_evt.code;
    assign out_ext   = head_evt.ext;
    assign out_break = head_evt.brk;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - self-checking bench for ps2_scancode_decoder
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_code;
    logic       out_ext;
    logic       out_break;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_ext   (out_ext),
        .out_break (out_break),
        .overflow  (overflow)
    );

    typedef struct {
        logic       iv;
        logic [7:0] b;
        logic       rdy;
        logic       ev;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [7:0] b, input logic rdy,
                       input logic ev, input logic [7:0] code,
                       input logic ext, input logic brk, input logic ovf);
        vec_t v;
        v.iv = iv; v.b = b; v.rdy = rdy; v.ev = ev;
        v.code = code; v.ext = ext; v.brk = brk; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic iv, input logic [7:0] b, input logic rdy);
        @(negedge clk);
        in_valid  = iv;
        in_byte   = b;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic [7:0] code,
                         input logic ext, input logic brk, input logic ovf);
        logic [11:0] act;
        logic [11:0] exp;
        act = {out_valid, out_code, out_ext, out_break, overflow};
        exp = {ev, code, ext, brk, ovf};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got valid=%b code=%h ext=%b brk=%b ovf=%b, want valid=%b code=%h ext=%b brk=%b ovf=%b",
                     name, act[11], act[10:3], act[2], act[1], act[0],
                     exp[11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        // Basic decode, prefixes, error resync, E1 and prefix interplay.
        add(1, 8'h1C, 1,  1, 8'h1C, 0, 0, 0);
        add(1, 8'hF0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'h1C, 1,  1, 8'h1C, 0, 1, 0);
        add(1, 8'hE0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'h75, 1,  1, 8'h75, 1, 0, 0);
        add(1, 8'hE0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'hF0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'h75, 1,  1, 8'h75, 1, 1, 0);
        add(1, 8'hE0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'hFF, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'h1C, 1,  1, 8'h1C, 0, 0, 0);
        add(1, 8'hF0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'hE0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'h12, 1,  1, 8'h12, 1, 0, 0);
        add(0, 8'h00, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'hF0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'hF0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'h00, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'hE1, 1,  1, 8'hE1, 0, 0, 0);
        add(1, 8'hE0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'hF0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'hF0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'hE0, 1,  0, 8'h00, 0, 0, 0);
        add(1, 8'h14, 1,  1, 8'h14, 1, 0, 0);
        add(0, 8'h00, 1,  0, 8'h00, 0, 0, 0);
        // Fill with consumer stalled, overflow on the fifth event.
        add(1, 8'h01, 0,  1, 8'h01, 0, 0, 0);
        add(1, 8'h02, 0,  1, 8'h01, 0, 0, 0);
        add(1, 8'h03, 0,  1, 8'h01, 0, 0, 0);
        add(1, 8'h04, 0,  1, 8'h01, 0, 0, 0);
        add(1, 8'h05, 0,  1, 8'h01, 0, 0, 1);
        add(0, 8'h00, 0,  1, 8'h01, 0, 0, 0);
        // Full FIFO with push and pop together, then drain in order.
        add(1, 8'h06, 1,  1, 8'h02, 0, 0, 0);
        add(0, 8'h00, 1,  1, 8'h03, 0, 0, 0);
        add(0, 8'h00, 1,  1, 8'h04, 0, 0, 0);
        add(0, 8'h00, 1,  1, 8'h06, 0, 0, 0);
        add(0, 8'h00, 1,  0, 8'h00, 0, 0, 0);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        #1;
        check("reset_hold", 0, 8'h00, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", 0, 8'h00, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].iv, vecs[i].b, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].code,
                  vecs[i].ext, vecs[i].brk, vecs[i].ovf);
        end

        // Byte arriving on the timeout cycle is still decoded as a break.
        step(1, 8'hF0, 1);
        repeat (TMO - 1) step(0, 8'h00, 1);
        step(1, 8'h1C, 1);
        check("tmo_edge_wins", 1, 8'h1C, 0, 1, 0);
        step(0, 8'h00, 1);
        check("tmo_edge_pop", 0, 8'h00, 0, 0, 0);

        // Prefix left idle for TIMEOUT_CYCLES is discarded.
        step(1, 8'hF0, 1);
        repeat (TMO) step(0, 8'h00, 1);
        check("tmo_no_event", 0, 8'h00, 0, 0, 0);
        step(1, 8'h1C, 1);
        check("tmo_expired", 1, 8'h1C, 0, 0, 0);
        step(0, 8'h00, 1);
        check("tmo_exp_pop", 0, 8'h00, 0, 0, 0);

        // Asynchronous reset mid E0 prefix with an event queued.
        step(1, 8'h1C, 0);
        check("rst_pre_evt", 1, 8'h1C, 0, 0, 0);
        step(1, 8'hE0, 0);
        check("rst_pre_ext", 1, 8'h1C, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_async", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h1C, 1);
        check("rst_after_1c", 1, 8'h1C, 0, 0, 0);
        step(0, 8'h00, 1);
        check("rst_after_pop", 0, 8'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the raw scan-code bytes assembled by the PS/2 keyboard serial receiver and turns them into key events: key code, extended flag and make/break flag. Sits directly downstream of the receiver, in the system clock domain, and buffers events in a small FIFO with a valid/ready output for the host-side consumer. Handles the E0 (extended) and F0 (break) prefixes. Resynchronises on line-error bytes and on prefix timeouts.

## Interface
Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 100000, clk cycles a prefix may wait for its next byte before it is discarded.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  single-cycle pulse: in_byte holds a new received byte, already synchronised to clk.
- in_byte  in  8  received scan-code byte.
- out_valid  out  1  FIFO non-empty; an event is presented.
- out_ready  in  1  consumer accepts the event when out_valid && out_ready.
- out_code  out  8  key code of the head event.
- out_ext  out  1  head event was E0-prefixed.
- out_break  out  1  head event is a release (F0-prefixed).
- overflow  out  1  one-cycle pulse: an event was dropped because the FIFO was full.

## Operation
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions happen only on in_valid, except for timeout.
- Error bytes are 0x00 and 0xFF. In any state an error byte sends the FSM to IDLE and emits no event.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - Any other byte → push {ext=0, brk=0, code}; stay in IDLE.
- EXT:
  - F0 → EXT_BRK.
  - E0 → stay in EXT.
  - Any other byte → push {1, 0, code}; go to IDLE.
- BRK:
  - F0 → stay in BRK.
  - E0 → EXT; the pending break is discarded.
  - Any other byte → push {0, 1, code}; go to IDLE.
- EXT_BRK:
  - F0 → stay in EXT_BRK.
  - E0 → EXT.
  - Any other byte → push {1, 1, code}; go to IDLE.
- E1 (Pause sequence) has no special handling. It is decoded as an ordinary code byte.
- Timeout counter:
  - Cleared on every in_valid and whenever the FSM is in IDLE.
  - Increments each cycle while the FSM is outside IDLE.
  - On reaching TIMEOUT_CYCLES−1, the FSM returns to IDLE and the counter clears.
  - If in_valid arrives in the same cycle as the timeout, in_valid wins and is decoded against the current state.
- FIFO behaviour:
  - Push on decode, pop on out_valid && out_ready.
  - Full with push and no pop: the new event is dropped and overflow pulses.
  - Full with push and pop in the same cycle: both succeed; no overflow.
  - Empty with push: no bypass.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a count of width $clog2(FIFO_DEPTH)+1.

## Timing
- Reset values: out_valid=0, out_code=0x00, out_ext=0, out_break=0, overflow=0. FSM in IDLE, FIFO empty, timeout counter 0.
- Reset asserted mid-sequence discards any pending prefix and all FIFO contents immediately, asynchronously.
- Latency: an event-completing in_valid at cycle N gives out_valid=1 with that event's data at cycle N+1.
- overflow is registered and high in cycle N+1 for a drop caused at cycle N.
- Event data on out_code, out_ext and out_break is stable while out_valid && !out_ready.
- After a pop, the next entry is presented in the following cycle.
- Back-to-back in_valid on consecutive cycles must be accepted; one byte per cycle throughput.

## Structure
- Shared package ps2_pkg holds:
  - FSM state enum.
  - Byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR0=8'h00, PS2_ERR1=8'hFF.
  - Packed event struct {ext, brk, code[7:0]} (10 bits).
- One sub-module: ps2_evt_fifo, a synchronous FIFO parameterised on depth and width, with push/pop, full/empty and the same clk/rst_n.
- The decoder FSM and the timeout counter live in ps2_scancode_decoder.

## Test plan
- IDLE, bytes 1C then F0,1C → events {1C,ext0,brk0} then {1C,ext0,brk1}; out_valid one cycle after each completing byte.
- E0,75 then E0,F0,75 → {75,1,0} then {75,1,1}; no events emitted for the prefix bytes.
- F0, then no input for TIMEOUT_CYCLES, then 1C → FSM back in IDLE; single event {1C,0,0}.
- E0,FF,1C → no event for FF; then {1C,0,0}.
- out_ready=0 with FIFO_DEPTH+1 plain codes 01..05 → FIFO holds 01..04; overflow pulses once for 05. Then out_ready=1 drains 01,02,03,04 in order.
- FIFO full with push and pop in the same cycle → no overflow, occupancy unchanged. rst_n low mid E0-prefix → outputs 0 at once; after release, 1C gives {1C,0,0}.
